// File: rtl/c3ud_pkg.sv
// rtl/c3ud_pkg.sv - shared types for the 3-bit up/down counter receive-side monitor
// Purpose: monitor FSM states, step classification codes and direction encoding.
// Ports: none (package).
package c3ud_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_UP   = 2'd1,
        ST_DN   = 2'd2,
        ST_JUMP = 2'd3
    } step_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/c3ud_step_cls.sv
// rtl/c3ud_step_cls.sv - combinational modulo-2^W step classifier
// Purpose: classify the move from prev to cnt as hold/up/down/jump and flag wrapping moves.
// Ports:
//   prev       in   W   previously sampled count
//   cnt        in   W   currently sampled count
//   step       out  2   step class (step_t)
//   wrap_cand  out  1   step is up from all-ones to zero or down from zero to all-ones
module c3ud_step_cls
    import c3ud_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0] prev,
    input  logic [W-1:0] cnt,
    output step_t        step,
    output logic         wrap_cand
);

    // W-bit arithmetic gives the modulo-2^W neighbours for free.
    logic [W-1:0] prev_inc;
    logic [W-1:0] prev_dec;

    assign prev_inc = prev + W'(1);
    assign prev_dec = prev - W'(1);

    always_comb begin
        step = ST_JUMP;
        if (cnt == prev) begin
            step = ST_HOLD;
        end else if (cnt == prev_inc) begin
            step = ST_UP;
        end else if (cnt == prev_dec) begin
            step = ST_DN;
        end
    end

    assign wrap_cand = ((step == ST_UP) && (prev == '1)) ||
                       ((step == ST_DN) && (prev == '0));

endmodule

// File: rtl/c3ud_decoder.sv
// rtl/c3ud_decoder.sv - receive-side monitor for a synchronous up/down counter
// Purpose: samples the count bus every clk, recovers counting direction, declares lock,
//          flags illegal steps, reversals and wrap events, and counts errors.
// Ports:
//   clk       in   1      rising-edge clock, same domain as the counter
//   res       in   1      asynchronous reset, active-low
//   en        in   1      counter enable aligned to cnt_in
//   cnt_in    in   W      sampled count value
//   dir       out  1      recovered direction (0 = up, 1 = down), valid while locked
//   locked    out  1      direction locked
//   step_err  out  1      one-cycle pulse on an illegal step
//   dir_chg   out  1      one-cycle pulse on a legal reversal while locked
//   wrap      out  1      one-cycle pulse on a legal wrapping step while locked
//   err_cnt   out  ERR_W  saturating count of step_err pulses
module c3ud_decoder
    import c3ud_pkg::*;
#(
    parameter int W      = 3,
    parameter int LOCK_N = 2,
    parameter int ERR_W  = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic [W-1:0]     cnt_in,
    output logic             dir,
    output logic             locked,
    output logic             step_err,
    output logic             dir_chg,
    output logic             wrap,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int RUN_W = $clog2(LOCK_N + 1);

    state_t             state_q, state_d;
    logic [W-1:0]       prev_q;
    logic [RUN_W-1:0]   run_q, run_d, run_inc;
    logic               dir_q, dir_d;
    logic               err_q, err_d;
    logic               chg_q, chg_d;
    logic               wrap_q, wrap_d;
    logic [ERR_W-1:0]   err_cnt_q;

    step_t              step;
    logic               wrap_cand;
    logic               legal;
    logic               moved;
    logic               step_dir;

    c3ud_step_cls #(.W(W)) u_step_cls (
        .prev      (prev_q),
        .cnt       (cnt_in),
        .step      (step),
        .wrap_cand (wrap_cand)
    );

    // A legal step is a single count move while enabled, or no change while disabled.
    assign moved    = en && ((step == ST_UP) || (step == ST_DN));
    assign legal    = moved || (!en && (step == ST_HOLD));
    assign step_dir = (step == ST_DN) ? DIR_DN : DIR_UP;
    assign run_inc  = (run_q >= RUN_W'(LOCK_N)) ? run_q : run_q + RUN_W'(1);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        dir_d   = dir_q;
        err_d   = 1'b0;
        chg_d   = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            SYNC: begin
                // First edge only establishes prev; nothing to compare against yet.
                state_d = ACQ;
                run_d   = '0;
            end
            ACQ: begin
                if (!legal) begin
                    err_d = 1'b1;
                    run_d = '0;
                end else if (moved) begin
                    if ((run_q == '0) || (step_dir == dir_q)) begin
                        run_d = run_inc;
                    end else begin
                        run_d = RUN_W'(1);
                    end
                    dir_d = step_dir;
                    if (run_d >= RUN_W'(LOCK_N)) begin
                        state_d = LOCK;
                        wrap_d  = wrap_cand;
                    end
                end
            end
            LOCK: begin
                if (!legal) begin
                    err_d   = 1'b1;
                    run_d   = '0;
                    state_d = ACQ;
                end else if (moved) begin
                    if (step_dir != dir_q) begin
                        dir_d = step_dir;
                        chg_d = 1'b1;
                    end
                    wrap_d = wrap_cand;
                end
            end
            default: begin
                state_d = SYNC;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q   <= SYNC;
            prev_q    <= '0;
            run_q     <= '0;
            dir_q     <= DIR_UP;
            err_q     <= 1'b0;
            chg_q     <= 1'b0;
            wrap_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            // prev tracks the bus unconditionally so the monitor resyncs after any error.
            prev_q  <= cnt_in;
            run_q   <= run_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            chg_q   <= chg_d;
            wrap_q  <= wrap_d;
            if (err_d && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
        end
    end

    assign dir      = dir_q;
    assign locked   = (state_q == LOCK);
    assign step_err = err_q;
    assign dir_chg  = chg_q;
    assign wrap     = wrap_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_c3ud_decoder.sv
// tb/tb_c3ud_decoder.sv - self-checking bench for c3ud_decoder
module tb_c3ud_decoder;

    localparam int W      = 3;
    localparam int LOCK_N = 2;
    localparam int ERR_W  = 4;
    localparam int MASK   = (1 << W) - 1;
    localparam int EMAX   = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             res;
    logic             en;
    logic [W-1:0]     cnt_in;
    logic             dir, locked, step_err, dir_chg, wrap;
    logic [ERR_W-1:0] err_cnt;

    int total = 0;
    int bad   = 0;

    c3ud_decoder #(.W(W), .LOCK_N(LOCK_N), .ERR_W(ERR_W)) dut (
        .clk      (clk),
        .res      (res),
        .en       (en),
        .cnt_in   (cnt_in),
        .dir      (dir),
        .locked   (locked),
        .step_err (step_err),
        .dir_chg  (dir_chg),
        .wrap     (wrap),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] cnt;
        logic       lk;
        logic       dr;
        logic       er;
        logic       ch;
        logic       wr;
        logic [3:0] ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic e, input int c, input logic lk, input logic dr,
                                input logic er, input logic ch, input logic wr, input int ec);
        vec_t v;
        v.en = e; v.cnt = 3'(c); v.lk = lk; v.dr = dr;
        v.er = er; v.ch = ch; v.wr = wr; v.ec = 4'(ec);
        return v;
    endfunction

    function automatic logic [8:0] pack(input logic lk, input logic dr, input logic er,
                                        input logic ch, input logic wr, input logic [3:0] ec);
        return {lk, dr, er, ch, wr, ec};
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = {locked, dir, step_err, dir_chg, wrap, err_cnt};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got lk/dir/err/chg/wrap/ec=%b required %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input int c);
        en     = e;
        cnt_in = 3'(c);
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: phase 0 = first sample, 1 = acquiring, 2 = locked.
    int   m_ph, m_prev, m_run, m_ec;
    logic m_dir, m_err, m_chg, m_wrap;

    task automatic model_reset();
        m_ph = 0; m_prev = 0; m_run = 0; m_ec = 0;
        m_dir = 1'b0; m_err = 1'b0; m_chg = 1'b0; m_wrap = 1'b0;
    endtask

    task automatic model_step(input logic e, input int c);
        int   delta;
        logic is_up, is_dn, ok, sd, wraps;
        m_err = 1'b0; m_chg = 1'b0; m_wrap = 1'b0;
        if (m_ph == 0) begin
            m_ph  = 1;
            m_run = 0;
        end else begin
            delta = (c - m_prev) & MASK;
            is_up = (delta == 1);
            is_dn = (delta == MASK);
            ok    = e ? (is_up || is_dn) : (delta == 0);
            if (!ok) begin
                m_err = 1'b1;
                m_ec  = (m_ec < EMAX) ? m_ec + 1 : EMAX;
                m_run = 0;
                m_ph  = 1;
            end else if (e) begin
                sd    = is_dn;
                wraps = is_up ? (m_prev == MASK) : (m_prev == 0);
                if (m_ph == 1) begin
                    m_run = (m_run == 0 || sd == m_dir) ? ((m_run < LOCK_N) ? m_run + 1 : LOCK_N) : 1;
                    m_dir = sd;
                    if (m_run >= LOCK_N) begin
                        m_ph   = 2;
                        m_wrap = wraps;
                    end
                end else begin
                    if (sd != m_dir) begin
                        m_chg = 1'b1;
                        m_dir = sd;
                    end
                    m_wrap = wraps;
                end
            end
        end
        m_prev = c;
    endtask

    initial begin
        int   ec_exp;
        int   p;
        int   r;
        int   c;
        logic e;
        logic mdir;

        // Tests 1-4 as one continuous vector table.
        // Test 1: up lock and 7->0 wrap.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0));
        for (int i = 3; i <= 7; i++) tbl.push_back(mk(1, i, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0));
        // Test 2: reversal at 5.
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(1, i, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 3, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0));
        // Test 3: back to up at 2, then jump 2->5 and relock on 7.
        tbl.push_back(mk(1, 2, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 5, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 6, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1));
        for (int i = 1; i <= 3; i++) tbl.push_back(mk(1, i, 1, 0, 0, 0, 0, 1));
        // Test 4: enable hold, change while disabled, stall while enabled, relock.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 3, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 4, 0, 0, 1, 0, 0, 2));
        tbl.push_back(mk(1, 4, 0, 0, 1, 0, 0, 3));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 3));

        res = 1'b0; en = 1'b0; cnt_in = '0;
        #1;
        check("reset_state", 9'b0);
        #11 res = 1'b1;
        #2;

        foreach (tbl[i]) begin
            drive(tbl[i].en, int'(tbl[i].cnt));
            check($sformatf("vec%0d_cnt%0d", i, tbl[i].cnt),
                  pack(tbl[i].lk, tbl[i].dr, tbl[i].er, tbl[i].ch, tbl[i].wr, tbl[i].ec));
        end

        // Test 5: 20 jumps of +3 starting from 6; err_cnt saturates at 15.
        ec_exp = 3;
        p = 6;
        for (int i = 0; i < 20; i++) begin
            p = (p + 3) & MASK;
            ec_exp = (ec_exp < EMAX) ? ec_exp + 1 : EMAX;
            drive(1'b1, p);
            check($sformatf("sat_jump%0d", i), pack(0, 0, 1, 0, 0, 4'(ec_exp)));
        end

        // Down lock with wrap on the locking edge 0->7 (prev is 2 here).
        drive(1'b1, 5); check("dn_pre_jump_a", pack(0, 0, 1, 0, 0, 15));
        drive(1'b1, 1); check("dn_pre_jump_b", pack(0, 0, 1, 0, 0, 15));
        drive(1'b1, 0); check("dn_acq", pack(0, 1, 0, 0, 0, 15));
        drive(1'b1, 7); check("dn_lock_wrap", pack(1, 1, 0, 0, 1, 15));
        drive(1'b1, 6); check("dn_locked", pack(1, 1, 0, 0, 0, 15));

        // Test 6: asynchronous reset between edges.
        @(negedge clk);
        res = 1'b0;
        #1;
        check("async_reset_clear", 9'b0);
        #2 res = 1'b1;
        drive(1'b1, 5); check("post_reset_sync", 9'b0);
        drive(1'b1, 6); check("post_reset_acq", 9'b0);
        drive(1'b1, 7); check("post_reset_lock", pack(1, 0, 0, 0, 0, 0));
        drive(1'b1, 0); check("post_reset_wrap", pack(1, 0, 0, 0, 1, 0));

        // Randomized run against the reference model.
        @(negedge clk);
        res = 1'b0;
        #2 res = 1'b1;
        model_reset();
        mdir = 1'b0;
        c = 0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) mdir = ~mdir;
            if (r < 65) begin
                e = 1'b1;
                c = mdir ? ((c - 1) & MASK) : ((c + 1) & MASK);
            end else if (r < 85) begin
                e = 1'b0;
            end else begin
                e = 1'($urandom_range(0, 1));
                c = $urandom_range(0, MASK);
            end
            model_step(e, c);
            drive(e, c);
            check($sformatf("rand%0d", i),
                  pack(m_ph == 2, m_dir, m_err, m_chg, m_wrap, 4'(m_ec)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
